// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS = 8;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data_byte,
                                           input logic par);
        return ^{data_byte, par};
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through FIFO; a pop frees a slot for a push in the same cycle.
module ps2_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign rd_valid = (count != '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && rd_valid;
    assign do_push  = push && (!full || do_pop);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (!do_push && do_pop)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding a FWFT FIFO with sticky overflow.
// Define PS2_TIMEOUT_EN to build the stuck-frame watchdog.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    input  logic                   rd_en,
    input  logic                   err_clr,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frame_err,
    output logic                   overflow
);

    logic       clk_s1, clk_s2, clk_prev;
    logic       data_s1, data_s2;
    logic       fall;
    ps2_state_t state;
    logic [2:0] bit_cnt;
    logic [PS2_DATA_BITS-1:0] shift_reg;
    logic       par_ok;
    logic       push, bad_frame, ovf_set, timeout, fifo_full;

    // Synchronizers idle high so reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall      = clk_prev & ~clk_s2;
    assign push      = fall && (state == STOP) && data_s2 && par_ok;
    assign bad_frame = fall && (state == STOP) && !(data_s2 && par_ok);
    assign ovf_set   = push && fifo_full && !(rd_en && rd_valid);

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] idle_cnt;

    assign timeout = (state != IDLE) && !fall && (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE || fall || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_ok    <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= timeout || bad_frame;
            overflow  <= ovf_set || (overflow && !err_clr);
            if (timeout) begin
                state <= IDLE;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {data_s2, shift_reg[PS2_DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        par_ok <= odd_parity_ok(shift_reg, data_s2);
                        state  <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    ps2_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PS2_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed scenarios plus randomized frames checked against a queue model.
module tb_ps2_rx_fifo;

    localparam int DEPTH       = 4;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HALF        = 40;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en    = 1'b0;
    logic       err_clr  = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] count;
    logic       frame_err;
    logic       overflow;

    int n_checks  = 0;
    int n_fail    = 0;
    int fe_pulses = 0;
    int fe_before;

    logic [7:0] model_q [$];
    logic       model_ovf = 1'b0;

    always #10 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Data changes mid-high so it is stable well before the falling edge.
    task automatic send_bit(input logic b, input bit pop_on_fall);
        ps2_data = b;
        tick(HALF / 2);
        ps2_clk = 1'b0;
        if (pop_on_fall) begin
            tick(2);
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
            tick(HALF - 3);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b1;
        tick(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_on_stop);
        logic par;
        par = (~^b) ^ bad_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit(par, 1'b0);
        send_bit(!bad_stop, pop_on_stop);
        tick(2);
    endtask

    // Reference: a good frame queues its byte unless the queue is full.
    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (!bad) begin
            if (model_q.size() == DEPTH) model_ovf = 1'b1;
            else model_q.push_back(b);
        end
    endtask

    task automatic read_one(input string tag);
        logic [7:0] exp;
        exp = model_q.pop_front();
        check_output({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check_output({tag, "_data"}, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        int         kind;
        int         nrd;

        tick(3);
        check_output("rst_valid", 32'(rd_valid), 32'd0);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_data", 32'(rd_data), 32'd0);
        check_output("rst_ferr", 32'(frame_err), 32'd0);
        check_output("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick(2);

        fe_before = fe_pulses;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        model_frame(8'h1C, 1'b0);
        check_output("t1_ferr", 32'(fe_pulses - fe_before), 32'd0);
        check_output("t1_count", 32'(count), 32'd1);
        read_one("t1_read");
        check_output("t1_empty_valid", 32'(rd_valid), 32'd0);
        check_output("t1_empty_count", 32'(count), 32'd0);

        fe_before = fe_pulses;
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        check_output("t2_ferr", 32'(fe_pulses - fe_before), 32'd1);
        check_output("t2_count", 32'(count), 32'd0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        model_frame(8'hF0, 1'b0);
        read_one("t2_read");

        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b0);
            model_frame(8'(i), 1'b0);
        end
        check_output("t3_count", 32'(count), 32'd4);
        check_output("t3_ovf", 32'(overflow), 32'(model_ovf));
        for (int i = 0; i < 4; i++) read_one("t3_read");
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        model_ovf = 1'b0;
        check_output("t3_ovf_clr", 32'(overflow), 32'd0);

        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b0);
            model_frame(8'(i), 1'b0);
        end
        send_frame(8'h66, 1'b0, 1'b0, 1'b1);
        void'(model_q.pop_front());
        model_q.push_back(8'h66);
        check_output("t4_ovf", 32'(overflow), 32'd0);
        check_output("t4_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) read_one("t4_read");

        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        fe_before = fe_pulses;
        tick(2100);
`ifdef PS2_TIMEOUT_EN
        check_output("t5_timeout_ferr", 32'(fe_pulses - fe_before), 32'd1);
`else
        check_output("t5_no_timeout_ferr", 32'(fe_pulses - fe_before), 32'd0);
        pulse_reset();
`endif
        check_output("t5_count", 32'(count), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        model_frame(8'h5A, 1'b0);
        read_one("t5_read");

        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        check_output("t6_pre_count", 32'(count), 32'd2);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        pulse_reset();
        check_output("t6_count", 32'(count), 32'd0);
        check_output("t6_valid", 32'(rd_valid), 32'd0);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        model_frame(8'h29, 1'b0);
        read_one("t6_read");

        for (int it = 0; it < 12; it++) begin
            rb   = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            fe_before = fe_pulses;
            send_frame(rb, kind == 0, kind == 1, 1'b0);
            model_frame(rb, kind < 2);
            check_output("rnd_ferr", 32'(fe_pulses - fe_before), (kind < 2) ? 32'd1 : 32'd0);
            check_output("rnd_count", 32'(count), 32'(model_q.size()));
            check_output("rnd_ovf", 32'(overflow), 32'(model_ovf));
            nrd = int'($urandom_range(0, 2));
            for (int r = 0; r < nrd; r++) begin
                if (model_q.size() > 0) read_one("rnd_read");
            end
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1;
                tick(1);
                err_clr = 1'b0;
                model_ovf = 1'b0;
                check_output("rnd_ovf_clr", 32'(overflow), 32'd0);
            end
        end
        while (model_q.size() > 0) read_one("rnd_drain");
        check_output("rnd_final_valid", 32'(rd_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
